// File: rtl/addkey_pkg.sv
// Shared constants, FSM state type and counter-width helper for the AddRoundKey accumulator.
package addkey_pkg;

   localparam int ADDKEY_WORD_W    = 32;
   localparam int ADDKEY_NUM_WORDS = 4;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   // A single-word block still needs a one-bit counter port.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/addkey_word_xor.sv
// One-column AddRoundKey: XOR of state word with key word, or pass-through when bypassed.
module addkey_word_xor #(
   parameter int WORD_W = 32
) (
   input  logic [WORD_W-1:0] i_word,
   input  logic [WORD_W-1:0] i_key,
   input  logic              i_bypass,
   output logic [WORD_W-1:0] o_word
);

   assign o_word = i_bypass ? i_word : (i_word ^ i_key);

endmodule

// File: rtl/addkey_accum.sv
// AddRoundKey column accumulator: XORs one word per cycle into a packed state, MSW first.
// Build option ADDKEY_BYPASS_EN adds key_bypass to store words without the key XOR.
//
//   state | meaning
//   FILL  | accepting words; word_cnt selects the slot written next
//   HOLD  | full block presented on data_out, waiting for out_ready
module addkey_accum
   import addkey_pkg::*;
#(
   parameter  int WORD_W    = ADDKEY_WORD_W,
   parameter  int NUM_WORDS = ADDKEY_NUM_WORDS,
   localparam int CNT_W     = cnt_width(NUM_WORDS),
   localparam int STATE_W   = WORD_W * NUM_WORDS
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               abort,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WORD_W-1:0]  in_word,
   input  logic [WORD_W-1:0]  key_word,
`ifdef ADDKEY_BYPASS_EN
   input  logic               key_bypass,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] data_out,
   output logic [CNT_W-1:0]   word_cnt
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [STATE_W-1:0] r_data;
   logic [WORD_W-1:0]  w_slot_word;
   logic               w_bypass;
   logic               w_write;
   logic               w_last;

`ifdef ADDKEY_BYPASS_EN
   assign w_bypass = key_bypass;
`else
   assign w_bypass = 1'b0;
`endif

   addkey_word_xor #(
      .WORD_W (WORD_W)
   ) u_word_xor (
      .i_word   (in_word),
      .i_key    (key_word),
      .i_bypass (w_bypass),
      .o_word   (w_slot_word)
   );

   assign w_last = (r_cnt == CNT_W'(NUM_WORDS - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_write     = 1'b0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         FILL: begin
            in_ready = 1'b1;
            if (abort) begin
               w_cnt_nxt = '0;
            end else if (in_valid) begin
               w_write = 1'b1;
               if (w_last) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = HOLD;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            // abort and out_ready leave HOLD identically; data is retained either way
            if (abort || out_ready) begin
               w_state_nxt = FILL;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = FILL;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= FILL;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Slot k sits at the MS end for k=0; unwritten slots keep the previous block.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_data <= '0;
      end else if (w_write) begin
         for (int k = 0; k < NUM_WORDS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
               r_data[STATE_W-1-k*WORD_W -: WORD_W] <= w_slot_word;
            end
         end
      end
   end

   assign data_out = r_data;
   assign word_cnt = r_cnt;

endmodule

// File: doc/addkey_accum.md
Name: addkey_accum

Overview:
Parametrised AddRoundKey column accumulator for the compact AES datapath. It accepts one state word per cycle over a valid/ready handshake and XORs it with the matching round-key word. Results are packed MSW-first into a full-width state register. Once all NUM_WORDS words are in, the state is presented on a valid/ready output port. This replaces index-driven column writes with an internal counter, backpressure, abort and a completion handshake.

Parameters:
WORD_W, 32, bits per state column / key word (multiple of 8)
NUM_WORDS, 4, columns per block; state width = WORD_W*NUM_WORDS (4 -> 128-bit AES state)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous, active-low reset
abort  in  1  synchronous clear of the in-progress block (active-high)
in_valid  in  1  in_word/key_word valid
in_ready  out  1  accumulator can take a word
in_word  in  WORD_W  state column, byte 0 in MS byte
key_word  in  WORD_W  round-key word for the same column
out_valid  out  1  data_out holds a complete block
out_ready  in  1  downstream accepts block
data_out  out  WORD_W*NUM_WORDS  packed result, word 0 at MS end
word_cnt  out  CNT_W  index of next slot to be written (debug/status)

Behaviour:
- Reset (reset_n=0 at posedge): state=FILL, word_cnt=0, out_valid=0, data_out=0. Reset overrides abort and all handshakes.
- FSM has two states, FILL and HOLD.
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: slot[word_cnt] <= in_word ^ key_word. Slot k occupies data_out[WORD_W*(NUM_WORDS-k)-1 -: WORD_W].
  - On an accept with word_cnt==NUM_WORDS-1: word_cnt<=0, go to HOLD.
  - Otherwise on accept: word_cnt<=word_cnt+1.
- HOLD:
  - in_ready=0, out_valid=1.
  - data_out is stable while out_valid=1 and out_ready=0.
  - On out_ready: go to FILL next cycle. There is no same-cycle refill; one bubble per block.
- Latency: the last word is accepted in cycle N; out_valid=1 in cycle N+1.
- Throughput: 1 block per NUM_WORDS+1 cycles with out_ready tied high.
- data_out is registered and has no combinational path from inputs.
- Slots not yet rewritten retain values from the previous block. data_out is defined only while out_valid=1.
- abort=1 in FILL: word_cnt<=0 and any accept that cycle is discarded (no slot write).
- abort=1 in HOLD: out_valid drops, go to FILL, word_cnt=0, data_out retained.
- abort and out_ready high together in HOLD: abort wins, with the same result as abort alone.
- in_valid while in_ready=0 is ignored; the upstream must hold its word.
- CNT_W = max(1, $clog2(NUM_WORDS)). The counter never exceeds NUM_WORDS-1.

Optional Feature:
ADDKEY_BYPASS_EN
- Defined: adds input port key_bypass (1 bit), sampled per accepted word. When 1, the slot is written with in_word unmodified; when 0, it is written with in_word ^ key_word. This supports the final-round/load paths without a separate mux.
- Undefined: the port is absent and the XOR is always applied.

Decomposition:
- Package addkey_pkg holds:
  - default WORD_W and NUM_WORDS constants
  - state enum typedef {FILL, HOLD}
  - CNT_W computation function
- One natural sub-module, addkey_word_xor: combinational WORD_W XOR with optional bypass, instantiated once ahead of the slot write.
- The FSM, counter and packing stay in the top module.

Test Plan:
- FIPS-197 round 0: feed words 3243f6a8, 885a308d, 313198a2, e0370734 with keys 2b7e1516, 28aed2a6, abf71588, 09cf4f3c, out_ready=1 -> data_out=193de3bea0f4e22b9ac68d2ae9f84808 and out_valid=1 for exactly one cycle, one cycle after the 4th accept.
- Backpressure: out_ready=0 for 10 cycles after completion -> out_valid and data_out stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> FILL and word_cnt=0 next cycle.
- Input gaps: in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 accepts and the same FIPS result; word_cnt steps 0,1,2,3,0.
- Abort mid-block: accept 2 words, assert abort with in_valid=1 -> word_cnt=0 and no write. The following 4 words produce the correct block unaffected by the aborted words.
- Reset mid-operation: reset_n=0 in HOLD with out_ready=0 -> next cycle out_valid=0, data_out=0, in_ready=1, word_cnt=0.
- Bypass (with ADDKEY_BYPASS_EN defined): key_bypass=1 on all words -> data_out=3243f6a8885a308d313198a2e0370734. Param sweep WORD_W=8, NUM_WORDS=16 -> byte-serial result matches the same FIPS vector.
